// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer_pkg
// Description : Shared CPU constants and types for the fetch sequencer:
//               datapath widths, folded/NOP opcodes and FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_sequencer_pkg;

  localparam int c_pc_w    = 8;
  localparam int c_instr_w = 16;
  localparam int c_cnt_w   = 16;

  // Immediate-jump opcode (instr[15:11]) folded away inside FETCH
  localparam logic [4:0]           c_opc_jmpi  = 5'b10011;
  // NOP word; issued like any other instruction
  localparam logic [c_instr_w-1:0] c_instr_nop = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : pc_reg
// Description : Program counter with synchronous load and wrapping increment.
//               Load takes priority over increment.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_reg
  import fetch_sequencer_pkg::*;
#(
  parameter logic [c_pc_w-1:0] RESET_PC = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [c_pc_w-1:0] load_val,
  input  logic              inc,
  output logic [c_pc_w-1:0] pc
);

  logic [c_pc_w-1:0] r_pc;

  // PC update: reset, then load, then natural-width wrapping increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (load) begin
      r_pc <= load_val;
    end else if (inc) begin
      r_pc <= r_pc + {{(c_pc_w-1){1'b0}}, 1'b1};
    end
  end

  assign pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Instruction fetch sequencer. Fetches from a combinational ROM,
//               folds immediate jumps, issues one instruction per handshake,
//               and supports redirect, halt and a saturating issue counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [c_pc_w-1:0] RESET_PC = 8'h00,
  parameter logic [4:0]        JMPI_OP  = c_opc_jmpi
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  output logic [c_pc_w-1:0]    rom_addr,
  input  logic [c_instr_w-1:0] rom_data,
  output logic [c_instr_w-1:0] instr,
  output logic [c_pc_w-1:0]    instr_pc,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  input  logic                 redirect,
  input  logic [c_pc_w-1:0]    redirect_pc,
  input  logic                 halt_req,
  output logic                 halted,
  output logic [c_cnt_w-1:0]   issue_cnt
);

  state_t               r_state;
  logic [c_instr_w-1:0] r_instr;
  logic [c_pc_w-1:0]    r_instr_pc;
  logic                 r_instr_valid;
  logic                 r_halted;
  logic [c_cnt_w-1:0]   r_issue_cnt;

  logic [c_pc_w-1:0]    w_pc;
  logic                 w_pc_load;
  logic [c_pc_w-1:0]    w_pc_load_val;
  logic                 w_pc_inc;
  logic                 w_is_jmpi;
  logic                 w_accept;
  logic [c_cnt_w-1:0]   w_cnt_next;

  assign w_is_jmpi  = (rom_data[15:11] == JMPI_OP);
  assign w_accept   = (r_state == ST_ISSUE) && r_instr_valid && instr_ready;
  assign w_cnt_next = (r_issue_cnt == {c_cnt_w{1'b1}}) ? r_issue_cnt
                                                       : r_issue_cnt + {{(c_cnt_w-1){1'b0}}, 1'b1};

  // PC control: redirect beats jump folding and the post-accept increment
  always_comb begin
    w_pc_load     = 1'b0;
    w_pc_load_val = w_pc;
    w_pc_inc      = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (redirect) begin
          w_pc_load     = 1'b1;
          w_pc_load_val = redirect_pc;
        end else if (!halt_req && w_is_jmpi) begin
          w_pc_load     = 1'b1;
          w_pc_load_val = rom_data[c_pc_w-1:0];
        end
      end
      ST_ISSUE: begin
        if (redirect) begin
          w_pc_load     = 1'b1;
          w_pc_load_val = redirect_pc;
        end else if (w_accept) begin
          w_pc_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_pc_load),
    .load_val (w_pc_load_val),
    .inc      (w_pc_inc),
    .pc       (w_pc)
  );

  // Sequencer FSM with registered issue outputs and counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_issue_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (halt_req) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else if (run) begin
            r_state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (redirect) begin
            r_state <= ST_FETCH;
          end else if (halt_req) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else if (!w_is_jmpi) begin
            r_instr       <= rom_data;
            r_instr_pc    <= w_pc;
            r_instr_valid <= 1'b1;
            r_state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (redirect) begin
            // A handshake completing alongside the redirect still counts
            if (w_accept) begin
              r_issue_cnt <= w_cnt_next;
            end
            r_instr_valid <= 1'b0;
            r_state       <= ST_FETCH;
          end else if (w_accept) begin
            r_issue_cnt   <= w_cnt_next;
            r_instr_valid <= 1'b0;
            if (halt_req) begin
              r_state  <= ST_HALT;
              r_halted <= 1'b1;
            end else begin
              r_state <= ST_FETCH;
            end
          end
        end
        ST_HALT: begin
          if (run && !halt_req) begin
            r_state  <= ST_FETCH;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_instr_valid <= 1'b0;
          r_halted      <= 1'b0;
        end
      endcase
    end
  end

  // Address is forced to the reset PC while reset is held
  assign rom_addr    = rst_n ? w_pc : RESET_PC;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;
  assign halted      = r_halted;
  assign issue_cnt   = r_issue_cnt;

endmodule
`default_nettype wire
